// File: rtl/fft16_pkg.sv
// Shared definitions for the 16-point FFT output serializer: default frame
// geometry, FSM state encoding and the 4-bit bin-index type.
package fft16_pkg;

   localparam int FFT16_N    = 16;
   localparam int FFT16_OUTW = 48;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_STREAM = 1'b1
   } state_t;

   typedef logic [3:0] bin_idx_t;

endpackage

// File: rtl/fft16_digit_rev.sv
// Maps a natural-order bin number k to the position p in the captured
// stage-2 frame that holds it.
// Macro FFT16_DIGIT_REV_EN: when defined, p is the radix-4 digit reversal of
// k; when undefined, p = k (raw stage-2 order passes straight through).
module fft16_digit_rev
   import fft16_pkg::*;
(
   input  bin_idx_t k,
   output bin_idx_t p
);

`ifdef FFT16_DIGIT_REV_EN
   // Swap the two base-4 digits of the bin number.
   assign p = {k[1:0], k[3:2]};
`else
   assign p = k;
`endif

endmodule

// File: rtl/fft16_output_serializer.sv
// Captures a full 16-bin stage-2 FFT frame on start and streams it out one
// bin per accepted valid/ready transfer, in natural bin order.
// Macro FFT16_DIGIT_REV_EN (see fft16_digit_rev) selects digit-reversed reads.
module fft16_output_serializer
   import fft16_pkg::*;
#(
   parameter int N    = FFT16_N,
   parameter int OUTW = FFT16_OUTW
)(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [N*OUTW-1:0]      yr_flat,
   input  logic [N*OUTW-1:0]      yi_flat,
   output logic                   m_valid,
   input  logic                   m_ready,
   output logic [3:0]             m_index,
   output logic signed [OUTW-1:0] m_re,
   output logic signed [OUTW-1:0] m_im,
   output logic                   m_last,
   output logic                   busy,
   output logic                   frame_done,
   output logic                   overrun
);

   state_t   state_q, state_d;
   bin_idx_t cnt_q, cnt_d;
   logic     frame_done_q, frame_done_d;
   logic     overrun_q, overrun_d;

   logic signed [OUTW-1:0] re_q [N];
   logic signed [OUTW-1:0] re_d [N];
   logic signed [OUTW-1:0] im_q [N];
   logic signed [OUTW-1:0] im_d [N];
   logic signed [OUTW-1:0] cap_re [N];
   logic signed [OUTW-1:0] cap_im [N];

   bin_idx_t rd_pos;
   logic     streaming;
   logic     xfer;
   logic     last_xfer;
   logic     capture;

   // Unpack the flat input buses into per-position words.
   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_unpack
         assign cap_re[gi] = yr_flat[gi*OUTW +: OUTW];
         assign cap_im[gi] = yi_flat[gi*OUTW +: OUTW];
      end
   endgenerate

   fft16_digit_rev u_digit_rev (
      .k (cnt_q),
      .p (rd_pos)
   );

   assign streaming = (state_q == ST_STREAM);
   assign xfer      = streaming && m_ready;
   assign last_xfer = xfer && (cnt_q == bin_idx_t'(N - 1));

   // Next-state logic: capture on start in IDLE or on the final transfer,
   // advance on each transfer, flag starts that would clobber a live frame.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      frame_done_d = 1'b0;
      overrun_d    = overrun_q;
      capture      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               capture = 1'b1;
               cnt_d   = '0;
               state_d = ST_STREAM;
            end
         end
         ST_STREAM: begin
            if (last_xfer) begin
               frame_done_d = 1'b1;
               cnt_d        = '0;
               if (start) begin
                  // Back-to-back frame: the slot just freed takes new data.
                  capture = 1'b1;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               if (xfer) begin
                  cnt_d = cnt_q + 1'b1;
               end
               if (start) begin
                  overrun_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Frame register update: load all positions at once when capturing.
   always_comb begin
      for (int i = 0; i < N; i++) begin
         re_d[i] = re_q[i];
         im_d[i] = im_q[i];
         if (capture) begin
            re_d[i] = cap_re[i];
            im_d[i] = cap_im[i];
         end
      end
   end

   // Control state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         frame_done_q <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         frame_done_q <= frame_done_d;
         overrun_q    <= overrun_d;
      end
   end

   // Frame storage registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N; i++) begin
            re_q[i] <= '0;
            im_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            re_q[i] <= re_d[i];
            im_q[i] <= im_d[i];
         end
      end
   end

   // Outputs come straight from state, so they hold while the sink stalls.
   assign m_valid    = streaming;
   assign busy       = streaming;
   assign m_index    = cnt_q;
   assign m_re       = re_q[rd_pos];
   assign m_im       = im_q[rd_pos];
   assign m_last     = streaming && (cnt_q == bin_idx_t'(N - 1));
   assign frame_done = frame_done_q;
   assign overrun    = overrun_q;

endmodule

// File: tb/tb_fft16_output_serializer.sv
// Self-checking bench for fft16_output_serializer: drives frames, varies
// m_ready, and compares every presented sample against a reference model.
module tb_fft16_output_serializer;

   localparam int N    = 16;
   localparam int OUTW = 48;

   logic                   clk = 1'b0;
   logic                   rst;
   logic                   start;
   logic [N*OUTW-1:0]      yr_flat;
   logic [N*OUTW-1:0]      yi_flat;
   logic                   m_valid;
   logic                   m_ready;
   logic [3:0]             m_index;
   logic signed [OUTW-1:0] m_re;
   logic signed [OUTW-1:0] m_im;
   logic                   m_last;
   logic                   busy;
   logic                   frame_done;
   logic                   overrun;

   int n_checks = 0;
   int n_fail   = 0;

   logic signed [OUTW-1:0] exp_re [N];
   logic signed [OUTW-1:0] exp_im [N];
   logic signed [OUTW-1:0] nxt_re [N];
   logic signed [OUTW-1:0] nxt_im [N];
   logic                   exp_overrun;

   fft16_output_serializer #(.N(N), .OUTW(OUTW)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .yr_flat    (yr_flat),
      .yi_flat    (yi_flat),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_index    (m_index),
      .m_re       (m_re),
      .m_im       (m_im),
      .m_last     (m_last),
      .busy       (busy),
      .frame_done (frame_done),
      .overrun    (overrun)
   );

   always #5 clk = ~clk;

   // Reference: captured position holding natural bin k.
   function automatic int exp_pos(input int k);
`ifdef FFT16_DIGIT_REV_EN
      return (k % 4) * 4 + (k / 4);
`else
      return k;
`endif
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_next();
      for (int i = 0; i < N; i++) begin
         yr_flat[i*OUTW +: OUTW] = nxt_re[i];
         yi_flat[i*OUTW +: OUTW] = nxt_im[i];
      end
   endtask

   task automatic adopt_next();
      for (int i = 0; i < N; i++) begin
         exp_re[i] = nxt_re[i];
         exp_im[i] = nxt_im[i];
      end
   endtask

   task automatic send_start();
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL start_idle: busy=%0b required 0", busy);
      end
      drive_next();
      start = 1'b1;
      tick();
      start = 1'b0;
      adopt_next();
   endtask

   // Streams the current frame. mode 0: ready always, 1: 1,0,0,1 pattern,
   // 2: random ready. inject_k: issue a start while bin inject_k is shown.
   // abort_k: return while bin abort_k is shown. chained: back-to-back taken.
   task automatic drain_frame(input int mode, input int inject_k, input int abort_k,
                              output bit chained);
      int  k = 0;
      int  c = 0;
      bit  injected = 1'b0;
      bit  xfer;
      int  p;
      chained = 1'b0;
      while (k < N) begin
         if (c > 400) begin
            n_checks++;
            n_fail++;
            $display("FAIL stream_timeout: bin=%0d never accepted within budget", k);
            return;
         end
         if (k == abort_k) return;
         case (mode)
            0:       m_ready = 1'b1;
            1:       m_ready = ((c % 4) == 0) || ((c % 4) == 3);
            default: m_ready = 1'($urandom_range(0, 1));
         endcase
         if (!injected && k == inject_k) begin
            injected = 1'b1;
            drive_next();
            start = 1'b1;
         end
         p = exp_pos(k);
         n_checks += 7;
         if (m_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL m_valid: bin=%0d got=%0b required 1", k, m_valid);
         end
         if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy: bin=%0d got=%0b required 1", k, busy);
         end
         if (m_index !== 4'(k)) begin
            n_fail++;
            $display("FAIL m_index: got=%0d required %0d", m_index, k);
         end
         if (m_re !== exp_re[p]) begin
            n_fail++;
            $display("FAIL m_re: bin=%0d got=%h required %h", k, m_re, exp_re[p]);
         end
         if (m_im !== exp_im[p]) begin
            n_fail++;
            $display("FAIL m_im: bin=%0d got=%h required %h", k, m_im, exp_im[p]);
         end
         if (m_last !== (k == N - 1)) begin
            n_fail++;
            $display("FAIL m_last: bin=%0d got=%0b required %0b", k, m_last, (k == N - 1));
         end
         if (overrun !== exp_overrun) begin
            n_fail++;
            $display("FAIL overrun: bin=%0d got=%0b required %0b", k, overrun, exp_overrun);
         end
         xfer = m_ready;
         if (start && !(xfer && k == N - 1)) exp_overrun = 1'b1;
         tick();
         if (start) begin
            start = 1'b0;
            if (xfer && k == N - 1) begin
               adopt_next();
               chained = 1'b1;
               n_checks += 4;
               if (frame_done !== 1'b1) begin
                  n_fail++;
                  $display("FAIL b2b_frame_done: got=%0b required 1", frame_done);
               end
               if (m_valid !== 1'b1) begin
                  n_fail++;
                  $display("FAIL b2b_valid: got=%0b required 1", m_valid);
               end
               if (m_index !== 4'd0) begin
                  n_fail++;
                  $display("FAIL b2b_index: got=%0d required 0", m_index);
               end
               if (overrun !== exp_overrun) begin
                  n_fail++;
                  $display("FAIL b2b_overrun: got=%0b required %0b", overrun, exp_overrun);
               end
               return;
            end
         end
         if (xfer) k++;
         c++;
      end
      n_checks += 5;
      if (frame_done !== 1'b1) begin
         n_fail++;
         $display("FAIL frame_done_pulse: got=%0b required 1", frame_done);
      end
      if (m_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL end_valid: got=%0b required 0", m_valid);
      end
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL end_busy: got=%0b required 0", busy);
      end
      if (m_last !== 1'b0) begin
         n_fail++;
         $display("FAIL end_last: got=%0b required 0", m_last);
      end
      if (overrun !== exp_overrun) begin
         n_fail++;
         $display("FAIL end_overrun: got=%0b required %0b", overrun, exp_overrun);
      end
      tick();
      n_checks++;
      if (frame_done !== 1'b0) begin
         n_fail++;
         $display("FAIL frame_done_width: got=%0b required 0", frame_done);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; m_ready = 1'b0; yr_flat = '0; yi_flat = '0;
      exp_overrun = 1'b0;
      #3;
      n_checks += 8;
      if (m_valid !== 1'b0)    begin n_fail++; $display("FAIL rst_valid: got=%0b required 0", m_valid); end
      if (busy !== 1'b0)       begin n_fail++; $display("FAIL rst_busy: got=%0b required 0", busy); end
      if (m_last !== 1'b0)     begin n_fail++; $display("FAIL rst_last: got=%0b required 0", m_last); end
      if (frame_done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got=%0b required 0", frame_done); end
      if (overrun !== 1'b0)    begin n_fail++; $display("FAIL rst_overrun: got=%0b required 0", overrun); end
      if (m_index !== 4'd0)    begin n_fail++; $display("FAIL rst_index: got=%0d required 0", m_index); end
      if (m_re !== '0)         begin n_fail++; $display("FAIL rst_re: got=%h required 0", m_re); end
      if (m_im !== '0)         begin n_fail++; $display("FAIL rst_im: got=%h required 0", m_im); end
      tick();
      tick();
      rst = 1'b0;
      tick();
      $display("test_reset done");
   endtask

   task automatic test_basic();
      bit ch;
      for (int p = 0; p < N; p++) begin
         nxt_re[p] = OUTW'(p + 1);
         nxt_im[p] = -OUTW'(p + 1);
      end
      send_start();
      drain_frame(0, -1, -1, ch);
      $display("test_basic done");
   endtask

   task automatic test_backpressure();
      bit ch;
      for (int p = 0; p < N; p++) begin
         nxt_re[p] = OUTW'(100 * p + 7);
         nxt_im[p] = -OUTW'(3 * p + 11);
      end
      send_start();
      drain_frame(1, -1, -1, ch);
      $display("test_backpressure done");
   endtask

   task automatic test_overrun();
      bit ch;
      for (int p = 0; p < N; p++) begin
         nxt_re[p] = OUTW'({16'($urandom), $urandom});
         nxt_im[p] = OUTW'({16'($urandom), $urandom});
      end
      send_start();
      for (int p = 0; p < N; p++) begin
         nxt_re[p] = OUTW'(p + 5000);
         nxt_im[p] = OUTW'(p + 6000);
      end
      drain_frame(1, 7, -1, ch);
      tick();
      n_checks++;
      if (overrun !== 1'b1) begin
         n_fail++;
         $display("FAIL overrun_sticky: got=%0b required 1", overrun);
      end
      $display("test_overrun done");
   endtask

   task automatic test_back_to_back();
      bit ch;
      for (int p = 0; p < N; p++) begin
         nxt_re[p] = OUTW'(p * 17 + 1);
         nxt_im[p] = OUTW'(p * 19 + 2);
      end
      send_start();
      for (int p = 0; p < N; p++) begin
         nxt_re[p] = OUTW'({16'($urandom), $urandom});
         nxt_im[p] = OUTW'({16'($urandom), $urandom});
      end
      drain_frame(0, N - 1, -1, ch);
      n_checks++;
      if (ch !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_taken: got=%0b required 1", ch);
      end
      drain_frame(0, -1, -1, ch);
      $display("test_back_to_back done");
   endtask

   task automatic test_reset_mid();
      bit ch;
      for (int p = 0; p < N; p++) begin
         nxt_re[p] = OUTW'(p + 900);
         nxt_im[p] = OUTW'(p + 950);
      end
      send_start();
      drain_frame(0, -1, 9, ch);
      #1 rst = 1'b1;
      #1;
      n_checks += 6;
      if (m_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid: got=%0b required 0", m_valid); end
      if (busy !== 1'b0)    begin n_fail++; $display("FAIL mid_rst_busy: got=%0b required 0", busy); end
      if (m_index !== 4'd0) begin n_fail++; $display("FAIL mid_rst_index: got=%0d required 0", m_index); end
      if (m_re !== '0)      begin n_fail++; $display("FAIL mid_rst_re: got=%h required 0", m_re); end
      if (m_im !== '0)      begin n_fail++; $display("FAIL mid_rst_im: got=%h required 0", m_im); end
      if (overrun !== 1'b0) begin n_fail++; $display("FAIL mid_rst_overrun: got=%0b required 0", overrun); end
      exp_overrun = 1'b0;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks += 2;
         if (frame_done !== 1'b0) begin n_fail++; $display("FAIL mid_rst_done: got=%0b required 0", frame_done); end
         if (m_valid !== 1'b0)    begin n_fail++; $display("FAIL mid_rst_idle: got=%0b required 0", m_valid); end
      end
      for (int p = 0; p < N; p++) begin
         nxt_re[p] = OUTW'(p + 1200);
         nxt_im[p] = OUTW'(p + 1300);
      end
      m_ready = 1'b0;
      send_start();
      drain_frame(2, -1, -1, ch);
      $display("test_reset_mid done");
   endtask

   task automatic test_extremes();
      bit ch;
      for (int p = 0; p < N; p++) begin
         nxt_re[p] = (p % 2 == 0) ? 48'sh7FFF_FFFF_FFFF : 48'sh8000_0000_0000;
         nxt_im[p] = (p % 2 == 0) ? 48'sh8000_0000_0000 : 48'sh7FFF_FFFF_FFFF;
      end
      send_start();
      drain_frame(0, -1, -1, ch);
      $display("test_extremes done");
   endtask

   task automatic test_random();
      bit ch;
      for (int f = 0; f < 4; f++) begin
         for (int p = 0; p < N; p++) begin
            nxt_re[p] = OUTW'({16'($urandom), $urandom});
            nxt_im[p] = OUTW'({16'($urandom), $urandom});
         end
         m_ready = 1'($urandom_range(0, 1));
         send_start();
         drain_frame(2, -1, -1, ch);
      end
      $display("test_random done");
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_extremes();
      test_back_to_back();
      test_random();
      test_reset_mid();
      test_overrun();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
